// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the 2-input gate checker.
package gate_chk_pkg;

  // Controller states: waiting, stepping through vectors, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Expected truth tables; bit index = {A,B}.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  // Number of input vectors for a 2-input gate.
  localparam int unsigned NUM_VEC = 4;

endpackage

// File: rtl/gate_truth_checker_hold_counter.sv
// Per-vector hold counter: counts clocks while enabled and flags the last
// hold cycle; wraps to zero on that cycle so the next vector starts fresh.
module hold_counter #(
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and wrap at the last hold cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/gate_truth_checker.sv
// Self-sequencing truth-table checker for a 2-input combinational gate.
// Steps {A,B} through 00,01,10,11, holds each HOLD_CYCLES clocks, samples
// the gate on the last hold cycle and compares against EXPECT.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 20,
  parameter logic [3:0]  EXPECT      = TT_NAND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  state_t      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [1:0]  ab_q, ab_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  fail_mask_q, fail_mask_d;

  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_tc;
  logic        sample;
  logic [3:0]  mismatch_vec;

  hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  // Per-vector compare of the gate output; X/Z counts as a mismatch in sim.
  for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_cmp
`ifndef SYNTHESIS
    assign mismatch_vec[gi] = (dut_out !== EXPECT[gi]);
`else
    assign mismatch_vec[gi] = (dut_out != EXPECT[gi]);
`endif
  end

  assign sample = (state_q == DRIVE) && cnt_tc;

  // State and registered-output flops, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= 2'd0;
      ab_q        <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      ab_q        <= ab_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  // Next-state: start only accepted in IDLE; DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (sample && (vec_q == 2'd3)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/outputs: vector stepping, sampling, and result registers.
  always_comb begin
    vec_d       = vec_q;
    ab_d        = ab_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d       = 2'd0;
          ab_d        = 2'd0;
          fail_mask_d = 4'd0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          cnt_clr     = 1'b1;
        end
      end
      DRIVE: begin
        cnt_en = 1'b1;
        if (sample) begin
          fail_mask_d[vec_q] = mismatch_vec[vec_q];
          if (vec_q == 2'd3) begin
            // Pass is taken from the mask including this last sample.
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = ~|fail_mask_d;
          end else begin
            vec_d = vec_q + 2'd1;
            ab_d  = vec_q + 2'd1;
          end
        end
      end
      DONE: begin
        vec_d = 2'd0;
        ab_d  = 2'd0;
      end
      default: begin
        vec_d = 2'd0;
        ab_d  = 2'd0;
      end
    endcase
  end

  assign a_out     = ab_q[1];
  assign b_out     = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;

endmodule
